sram_controller_param: RTL and testbench
========================================

Name: sram_controller_param

Overview:
- Parametrised external-SRAM controller for the ARM pipeline MEM stage.
- Accepts one host word access (read or write) and splits it into DATA_W/SRAM_DQ_W sequential half-word beats on the SRAM bus.
- Each beat is held for a programmable number of wait states.
- Stalls the pipeline via `ready` until the access completes.
- Generalises the fixed 32/16-bit, fixed-timing controller to arbitrary widths, address base and wait states, and adds chip/output-enable sequencing.

Parameters:
- DATA_W, 32: host data width; must be an integer multiple of SRAM_DQ_W.
- SRAM_DQ_W, 16: SRAM data bus width.
- SRAM_AW, 18: SRAM address width.
- ADDR_BASE, 1024: host byte address mapped to SRAM word 0.
- WAIT_STATES, 1: extra cycles each beat is held; range 0..15.
- Derived: BEATS = DATA_W/SRAM_DQ_W, which must be a power of two. BYTE_SH = log2(DATA_W/8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- wrEn  in  1  write request.
- rdEn  in  1  read request.
- address  in  32  host byte address.
- writeData  in  DATA_W  write data.
- readData  out  DATA_W  read data register.
- ready  out  1  high when the host may proceed.
- SRAM_DQ  inout  SRAM_DQ_W  SRAM data bus.
- SRAM_ADDR  out  SRAM_AW  SRAM address.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_UB_N  out  1  upper byte enable, active low.
- SRAM_LB_N  out  1  lower byte enable, active low.
- SRAM_CE_N  out  1  chip enable, active low.
- SRAM_OE_N  out  1  output enable, active low.

Behaviour:
- States: IDLE, WRITE, READ, DONE.
- Counters:
  - beat counter, log2(BEATS) bits (minimum 1);
  - wait counter, 4 bits.
- Reset (rst=0, asynchronous):
  - state=IDLE, counters=0, readData=0, latched address/data=0.
  - Outputs: SRAM_WE_N=1, SRAM_CE_N=1, SRAM_OE_N=1, SRAM_UB_N=1, SRAM_LB_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
  - ready=1 while wrEn=rdEn=0.
- IDLE:
  - ready = !(wrEn|rdEn), combinational, so the stage stalls in the request cycle itself.
  - On wrEn, go to WRITE. Write wins if wrEn and rdEn are both high.
  - Else on rdEn, go to READ.
  - On the accept edge, latch the word index, writeData and the op; beat=0, wait=0.
- Word index = ((address - ADDR_BASE) >> BYTE_SH), unsigned 32-bit subtraction.
- SRAM_ADDR = word_index*BEATS + beat, truncated to SRAM_AW. Addresses below ADDR_BASE wrap; there is no error.
- WRITE/READ:
  - CE_N=0, UB_N=0, LB_N=0, ready=0.
  - Each beat lasts WAIT_STATES+1 cycles. wait increments; when wait==WAIT_STATES, wait returns to 0 and beat increments.
  - After the last cycle of beat BEATS-1, go to DONE.
- WRITE:
  - SRAM_WE_N=0 and SRAM_OE_N=1 for all beat cycles except the last cycle of each beat, where WE_N=1. This gives a WE rising edge with data still stable.
  - SRAM_DQ driven with latched_data[beat*SRAM_DQ_W +: SRAM_DQ_W]; beat 0 is the least significant slice.
- READ:
  - SRAM_OE_N=0, WE_N=1, SRAM_DQ=Z.
  - On the last cycle of each beat, capture SRAM_DQ into readData[beat*SRAM_DQ_W +: SRAM_DQ_W].
  - readData holds between reads; writes never alter it.
- DONE:
  - ready=1 for exactly one cycle. CE_N=1, OE_N=1, WE_N=1, DQ=Z. Next state IDLE.
  - readData is final and valid in DONE.
  - Requests seen in DONE are ignored.
  - A request still high in the following IDLE cycle starts a new access; the host must drop or change its request after seeing ready.
- Latency: request cycle + BEATS*(WAIT_STATES+1) + DONE. ready rises BEATS*(WAIT_STATES+1)+1 cycles after the request is first sampled. Defaults give 5 cycles.
- wrEn, rdEn, address and writeData changes after acceptance are ignored until IDLE.
- Reset mid-access: immediate return to the reset values; a partial write is not completed; readData is cleared to 0.
- SRAM_DQ is driven only in WRITE; it is never driven in the same cycle as OE_N=0.

Test Plan:
- Defaults; write address=1024, writeData=0x12345678 -> SRAM_ADDR 0 gets 0x5678, then SRAM_ADDR 1 gets 0x1234. WE_N is low 1 cycle per beat. ready=0 for 4 cycles, then 1 in DONE (5th cycle).
- Defaults; read address=1032 with SRAM model [4]=0xBEEF, [5]=0xCAFE -> readData=0xCAFEBEEF when ready=1. DQ is Z and OE_N=0 throughout the reads.
- wrEn=rdEn=1 at address 1028 -> write performed to SRAM_ADDR 2/3; readData unchanged.
- WAIT_STATES=0 and WAIT_STATES=3 -> ready latency 3 and 9 cycles respectively. DATA_W=64/SRAM_DQ_W=16 -> 4 beats at consecutive SRAM addresses, latency 9 at WAIT_STATES=1.
- Assert rst=0 during beat 1 of a write -> same-cycle WE_N=1, CE_N=1, DQ=Z, readData=0. After release, ready=1 in IDLE with no request.
- address=1020 (below base) -> SRAM_ADDR wraps to 0x3FFFE (BEATS=2, SRAM_AW=18) with no hang; back-to-back read then write completes with no DQ contention.

Source files
------------

// File: rtl/sram_controller_param.sv
// External SRAM controller: splits one host word access into BEATS half-word
// bus beats, each held for WAIT_STATES+1 cycles, stalling the host via ready.
module sram_controller_param #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SRAM_DQ_W   = 16,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrEn,
    input  logic                 rdEn,
    input  logic [31:0]          address,
    input  logic [DATA_W-1:0]    writeData,
    output logic [DATA_W-1:0]    readData,
    output logic                 ready,
    inout  wire  [SRAM_DQ_W-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N
);

    localparam int unsigned BEATS     = DATA_W / SRAM_DQ_W;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BEAT_SH   = $clog2(BEATS);
    localparam int unsigned BYTE_SH   = $clog2(DATA_W / 8);
    localparam logic [3:0]  WAIT_MAX  = 4'(WAIT_STATES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [3:0]           wait_q, wait_d;
    logic [SRAM_AW-1:0]   word_q, word_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic [31:0]          offset;
    logic                 beat_end;
    logic                 dq_oe;
    logic [SRAM_DQ_W-1:0] dq_out;

    assign offset    = address - 32'(ADDR_BASE);
    assign beat_end  = (wait_q == WAIT_MAX);
    assign dq_out    = wdata_q[beat_q*SRAM_DQ_W +: SRAM_DQ_W];
    assign SRAM_DQ   = dq_oe ? dq_out : 'z;
    // Word index is pre-truncated to SRAM_AW; the low bits alone determine the bus address.
    assign SRAM_ADDR = (word_q << BEAT_SH) + SRAM_AW'(beat_q);
    assign readData  = rdata_q;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready     = 1'b0;
        dq_oe     = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;

        case (state_q)
            IDLE: begin
                ready = !(wrEn || rdEn);
                if (wrEn || rdEn) begin
                    state_d = wrEn ? WRITE : READ;
                    word_d  = SRAM_AW'(offset >> BYTE_SH);
                    wdata_d = writeData;
                    beat_d  = '0;
                    wait_d  = '0;
                end
            end
            WRITE, READ: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (state_q == WRITE) begin
                    // WE rises on the final cycle of the beat while data is still driven.
                    SRAM_WE_N = beat_end;
                    dq_oe     = 1'b1;
                end else begin
                    SRAM_OE_N = 1'b0;
                    if (beat_end) begin
                        rdata_d[beat_q*SRAM_DQ_W +: SRAM_DQ_W] = SRAM_DQ;
                    end
                end
                if (beat_end) begin
                    wait_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_controller_param.sv
// Directed bench for sram_controller_param: default instance plus wait-state
// and 64-bit variants for latency and beat ordering.
module tb_sram_controller_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr, rd;
    logic [31:0] addr, wd, rdata;
    logic        rdy;
    wire  [15:0] dq;
    logic [17:0] sa;
    logic        we_n, ub_n, lb_n, ce_n, oe_n;

    int tests = 0;
    int fails = 0;

    function automatic logic [15:0] rd_model(input logic [17:0] a);
        if (a == 18'd4) return 16'hBEEF;
        if (a == 18'd5) return 16'hCAFE;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    assign dq = oe_n ? 16'hzzzz : rd_model(sa);

    sram_controller_param dut (
        .clk(clk), .rst(rst), .wrEn(wr), .rdEn(rd), .address(addr),
        .writeData(wd), .readData(rdata), .ready(rdy), .SRAM_DQ(dq),
        .SRAM_ADDR(sa), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    // Variant instances, write-only
    logic [2:0]  lx, rdy_x;
    logic [31:0] rd_w0, rd_w3;
    logic [63:0] rd_64;
    logic [63:0] wd64 = 64'h1122334455667788;
    wire  [15:0] dq_w0, dq_w3, dq_64;
    logic [17:0] sa_x [3];
    logic        we_x [3], ub_x [3], lb_x [3], ce_x [3], oe_x [3];

    sram_controller_param #(.WAIT_STATES(0)) dut_w0 (
        .clk(clk), .rst(rst), .wrEn(lx[0]), .rdEn(1'b0), .address(addr),
        .writeData(wd), .readData(rd_w0), .ready(rdy_x[0]), .SRAM_DQ(dq_w0),
        .SRAM_ADDR(sa_x[0]), .SRAM_WE_N(we_x[0]), .SRAM_UB_N(ub_x[0]), .SRAM_LB_N(lb_x[0]),
        .SRAM_CE_N(ce_x[0]), .SRAM_OE_N(oe_x[0])
    );
    sram_controller_param #(.WAIT_STATES(3)) dut_w3 (
        .clk(clk), .rst(rst), .wrEn(lx[1]), .rdEn(1'b0), .address(addr),
        .writeData(wd), .readData(rd_w3), .ready(rdy_x[1]), .SRAM_DQ(dq_w3),
        .SRAM_ADDR(sa_x[1]), .SRAM_WE_N(we_x[1]), .SRAM_UB_N(ub_x[1]), .SRAM_LB_N(lb_x[1]),
        .SRAM_CE_N(ce_x[1]), .SRAM_OE_N(oe_x[1])
    );
    sram_controller_param #(.DATA_W(64), .SRAM_DQ_W(16)) dut_64 (
        .clk(clk), .rst(rst), .wrEn(lx[2]), .rdEn(1'b0), .address(addr),
        .writeData(wd64), .readData(rd_64), .ready(rdy_x[2]), .SRAM_DQ(dq_64),
        .SRAM_ADDR(sa_x[2]), .SRAM_WE_N(we_x[2]), .SRAM_UB_N(ub_x[2]), .SRAM_LB_N(lb_x[2]),
        .SRAM_CE_N(ce_x[2]), .SRAM_OE_N(oe_x[2])
    );

    logic [17:0] log_a [8];
    logic [15:0] log_d [8];
    int n64 = 0;
    always @(posedge clk) begin
        if (!ce_x[2] && !we_x[2]) begin
            if (n64 < 8) begin
                log_a[n64] <= sa_x[2];
                log_d[n64] <= dq_64;
            end
            n64 <= n64 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The controller must never drive DQ while the SRAM output is enabled.
    always @(negedge clk) begin
        if (rst && !oe_n) chk("dq_contention", 64'(dut.dq_oe), 64'd0);
    end

    task automatic bus_chk(input string tag, input logic e_rdy, input logic e_ce,
                           input logic e_oe, input logic e_we, input logic [17:0] e_sa,
                           input logic e_dqoe);
        chk({tag, "_ready"}, 64'(rdy), 64'(e_rdy));
        chk({tag, "_ce_n"},  64'(ce_n), 64'(e_ce));
        chk({tag, "_ub_n"},  64'(ub_n), 64'(e_ce));
        chk({tag, "_lb_n"},  64'(lb_n), 64'(e_ce));
        chk({tag, "_oe_n"},  64'(oe_n), 64'(e_oe));
        chk({tag, "_we_n"},  64'(we_n), 64'(e_we));
        chk({tag, "_addr"},  64'(sa),   64'(e_sa));
        chk({tag, "_dq_oe"}, 64'(dut.dq_oe), 64'(e_dqoe));
    endtask

    // Four active cycles (2 beats x 2 cycles) then DONE, for the default instance.
    task automatic run_access(input string tag, input logic is_wr, input logic [17:0] a0,
                              input logic [31:0] data);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_chk($sformatf("%s_c%0d", tag, i + 1), 1'b0, 1'b0, is_wr,
                    is_wr ? (i % 2 == 1) : 1'b1, a0 + 18'(i / 2), is_wr);
            if (is_wr) chk($sformatf("%s_dq%0d", tag, i + 1), 64'(dq), 64'(data[16*(i/2) +: 16]));
        end
        @(negedge clk);
        bus_chk({tag, "_done"}, 1'b1, 1'b1, 1'b1, 1'b1, a0 + 18'd1, 1'b0);
        if (!is_wr) chk({tag, "_rdata"}, 64'(rdata), 64'(data));
    endtask

    task automatic latency(input int which, input int exp, input string tag);
        int n = 0;
        lx[which] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy_x[which] && n < 40);
        lx = '0;
        chk(tag, 64'(n), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wd = '0; lx = '0;
        repeat (2) @(negedge clk);
        bus_chk("reset", 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        addr = 32'd1024; wd = 32'h12345678; wr = 1'b1;
        #1 chk("wr_req_ready", 64'(rdy), 64'd0);
        run_access("wr", 1'b1, 18'd0, 32'h12345678);
        wr = 1'b0;
        @(negedge clk);
        chk("wr_idle_ready", 64'(rdy), 64'd1);
        chk("wr_rdata_kept", 64'(rdata), 64'd0);

        addr = 32'd1032; rd = 1'b1;
        #1 chk("rd_req_ready", 64'(rdy), 64'd0);
        run_access("rd", 1'b0, 18'd4, 32'hCAFEBEEF);
        rd = 1'b0;
        @(negedge clk);

        addr = 32'd1028; wd = 32'hA1B2C3D4; wr = 1'b1; rd = 1'b1;
        #1 chk("both_req_ready", 64'(rdy), 64'd0);
        run_access("both", 1'b1, 18'd2, 32'hA1B2C3D4);
        wr = 1'b0; rd = 1'b0;
        chk("both_rdata_kept", 64'(rdata), 64'hCAFEBEEF);
        @(negedge clk);

        addr = 32'd1024; wd = 32'hDEADBEEF; wr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pre_we_n", 64'(we_n), 64'd0);
        chk("rst_pre_addr", 64'(sa), 64'd1);
        wr = 1'b0; rst = 1'b0;
        #1 bus_chk("rst_mid", 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0);
        chk("rst_mid_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_chk("rst_after", 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0);

        addr = 32'd1020; rd = 1'b1;
        #1 chk("wrap_req_ready", 64'(rdy), 64'd0);
        run_access("wrap_rd", 1'b0, 18'h3FFFE, 32'hA5A5A5A4);
        rd = 1'b0; wr = 1'b1; wd = 32'h0BADF00D;
        #1 chk("b2b_done_ready", 64'(rdy), 64'd1);
        @(negedge clk);
        chk("b2b_idle_ready", 64'(rdy), 64'd0);
        chk("b2b_idle_dq_oe", 64'(dut.dq_oe), 64'd0);
        run_access("wrap_wr", 1'b1, 18'h3FFFE, 32'h0BADF00D);
        wr = 1'b0;
        chk("wrap_rdata_kept", 64'(rdata), 64'hA5A5A5A4);
        @(negedge clk);

        latency(0, 3, "lat_ws0");
        latency(1, 9, "lat_ws3");
        addr = 32'd1048;
        latency(2, 9, "lat_dw64");
        chk("dw64_beats", 64'(n64), 64'd4);
        chk("dw64_a0", 64'(log_a[0]), 64'd12);
        chk("dw64_a1", 64'(log_a[1]), 64'd13);
        chk("dw64_a2", 64'(log_a[2]), 64'd14);
        chk("dw64_a3", 64'(log_a[3]), 64'd15);
        chk("dw64_d0", 64'(log_d[0]), 64'h7788);
        chk("dw64_d1", 64'(log_d[1]), 64'h5566);
        chk("dw64_d2", 64'(log_d[2]), 64'h3344);
        chk("dw64_d3", 64'(log_d[3]), 64'h1122);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
